// File: rtl/key_detect_pkg.sv
// Shared types and helpers for the multi-channel key debouncer.
package key_detect_pkg;

  // Per-channel debounce / hold state
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEB_DOWN = 3'd1,
    PRESSED  = 3'd2,
    LONG     = 3'd3,
    DEB_UP   = 3'd4
  } state_t;

  // Width of a counter that must hold the largest of three terminal counts
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_detect_chan.sv
// One key channel: 2-FF synchroniser, debounce/hold FSM and a shared counter.
// All outputs are registered; pulses are exactly one clock wide.
module key_detect_chan
  import key_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 200,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_state,
  output logic press_down,
  output logic press_up,
  output logic long_press,
  output logic repeat_tick
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, REPEAT_CYCLES);
  // Pin level of a released key; also the value XOR-ed away to get "pressed"
  localparam logic REL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] C_DEB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LONG = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] C_REP  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_p;
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_was_long;
  logic          w_was_long_next;
  logic          r_key_state;
  logic          w_key_state_next;
  logic          r_press_down;
  logic          w_press_down_next;
  logic          r_press_up;
  logic          w_press_up_next;
  logic          r_long_press;
  logic          w_long_press_next;
  logic          r_repeat_tick;
  logic          w_repeat_tick_next;

  // Two-flop synchroniser; reset preloads the released level so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL;
      r_sync2 <= REL;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised "pressed" level
  assign w_p = r_sync2 ^ REL;

  // State, counter, flag and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_was_long    <= 1'b0;
      r_key_state   <= 1'b0;
      r_press_down  <= 1'b0;
      r_press_up    <= 1'b0;
      r_long_press  <= 1'b0;
      r_repeat_tick <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_was_long    <= w_was_long_next;
      r_key_state   <= w_key_state_next;
      r_press_down  <= w_press_down_next;
      r_press_up    <= w_press_up_next;
      r_long_press  <= w_long_press_next;
      r_repeat_tick <= w_repeat_tick_next;
    end
  end

  // Next-state and pulse decode; every terminal compare clears the counter so it cannot wrap
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_was_long_next    = r_was_long;
    w_key_state_next   = r_key_state;
    w_press_down_next  = 1'b0;
    w_press_up_next    = 1'b0;
    w_long_press_next  = 1'b0;
    w_repeat_tick_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_p) begin
          w_state_next = DEB_DOWN;
          w_cnt_next   = C_ONE;
        end
      end
      DEB_DOWN: begin
        if (!w_p) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == C_DEB) begin
          w_state_next      = PRESSED;
          w_press_down_next = 1'b1;
          w_key_state_next  = 1'b1;
          w_cnt_next        = '0;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      PRESSED: begin
        if (!w_p) begin
          w_state_next = DEB_UP;
          w_cnt_next   = C_ONE;
        end else if (r_cnt == C_LONG) begin
          w_state_next      = LONG;
          w_long_press_next = 1'b1;
          w_was_long_next   = 1'b1;
          w_cnt_next        = '0;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      LONG: begin
        if (!w_p) begin
          w_state_next = DEB_UP;
          w_cnt_next   = C_ONE;
        end else if (r_cnt == C_REP) begin
          w_repeat_tick_next = 1'b1;
          w_cnt_next         = '0;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      DEB_UP: begin
        if (w_p) begin
          // Release was a bounce: resume holding, but restart the hold count
          w_state_next = r_was_long ? LONG : PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == C_DEB) begin
          w_state_next     = IDLE;
          w_press_up_next  = 1'b1;
          w_key_state_next = 1'b0;
          w_was_long_next  = 1'b0;
          w_cnt_next       = '0;
        end else begin
          w_cnt_next = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign key_state   = r_key_state;
  assign press_down  = r_press_down;
  assign press_up    = r_press_up;
  assign long_press  = r_long_press;
  assign repeat_tick = r_repeat_tick;

endmodule

// File: rtl/key_detect_multi.sv
// Multi-channel push-button debouncer / event detector.
// Each key gets an independent channel; the top only gathers their outputs into vectors.
module key_detect_multi
  import key_detect_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = 50,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter int REPEAT_CYCLES     = 200,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_down,
  output logic [NUM_KEYS-1:0] press_up,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] repeat_tick
);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    key_detect_chan #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .key        (key[gi]),
      .key_state  (key_state[gi]),
      .press_down (press_down[gi]),
      .press_up   (press_up[gi]),
      .long_press (long_press[gi]),
      .repeat_tick(repeat_tick[gi])
    );
  end

endmodule
